// File: rtl/zhyperram_bus_arbiter.sv
// Two-requester arbiter for the shared HyperRAM pad group: exclusive grants, a fixed
// High-Z turnaround between owners, round-robin tie breaking and an optional hold limit.
module zhyperram_bus_arbiter #(
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned MAX_HOLD    = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic iClk,
  input  logic iRst_N,
  input  logic iReq1,
  input  logic iReq2,
  input  logic iDone1,
  input  logic iDone2,
  input  logic iOE1,
  input  logic iOE2,
  output logic oGnt1,
  output logic oGnt2,
  output logic oWhichWr,
  output logic oTriState,
  output logic oBusy,
  output logic oTimeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT1 = 2'd1,
    ST_GNT2 = 2'd2,
    ST_TURN = 2'd3
  } state_e;

  localparam bit               HOLD_EN   = (MAX_HOLD != 32'd0);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 32'd0) ? 32'd0 : MAX_HOLD - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);
  localparam logic [3:0]       TURN_LAST = 4'(TURN_CYCLES - 32'd1);

  state_e           state_q, state_d;
  logic             last2_q, last2_d;        // 1 = requester 2 was the last owner
  logic             which_wr_q, which_wr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       turn_q, turn_d;
  logic             timeout_q, timeout_d;
  state_e           arb_s;

  // Pick the next owner; on a tie the side that did not own the bus last wins.
  function automatic state_e arbitrate(input logic req1, input logic req2, input logic last2);
    state_e res;
    if (req1 && req2) begin
      res = last2 ? ST_GNT1 : ST_GNT2;
    end else if (req1) begin
      res = ST_GNT1;
    end else if (req2) begin
      res = ST_GNT2;
    end else begin
      res = ST_IDLE;
    end
    return res;
  endfunction

  // Next-state, counter and select logic.
  always_comb begin
    state_d    = state_q;
    last2_d    = last2_q;
    which_wr_d = which_wr_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    timeout_d  = 1'b0;
    arb_s      = arbitrate(iReq1, iReq2, last2_q);

    case (state_q)
      ST_IDLE: begin
        state_d = arb_s;
        if (arb_s != ST_IDLE) begin
          hold_d     = '0;
          which_wr_d = (arb_s == ST_GNT2);
          last2_d    = (arb_s == ST_GNT2);
        end else begin
          hold_d = hold_q;
        end
      end
      ST_GNT1, ST_GNT2: begin
        // Release wins over timeout when both happen in the same cycle.
        if ((state_q == ST_GNT1) ? (iDone1 || !iReq1) : (iDone2 || !iReq2)) begin
          state_d = ST_TURN;
          turn_d  = 4'd0;
        end else if (HOLD_EN && (hold_q == HOLD_LAST) &&
                     ((state_q == ST_GNT1) ? iReq2 : iReq1)) begin
          state_d   = ST_TURN;
          turn_d    = 4'd0;
          timeout_d = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end else begin
          hold_d = hold_q;
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = arb_s;
          if (arb_s != ST_IDLE) begin
            hold_d     = '0;
            which_wr_d = (arb_s == ST_GNT2);
            last2_d    = (arb_s == ST_GNT2);
          end else begin
            hold_d = hold_q;
          end
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iRst_N) begin
      state_q    <= ST_IDLE;
      last2_q    <= 1'b1;
      which_wr_q <= 1'b0;
      hold_q     <= '0;
      turn_q     <= 4'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last2_q    <= last2_d;
      which_wr_q <= which_wr_d;
      hold_q     <= hold_d;
      turn_q     <= turn_d;
      timeout_q  <= timeout_d;
    end
  end

  assign oGnt1     = (state_q == ST_GNT1);
  assign oGnt2     = (state_q == ST_GNT2);
  assign oWhichWr  = which_wr_q;
  assign oBusy     = (state_q != ST_IDLE);
  assign oTimeout  = timeout_q;
  assign oTriState = ((state_q == ST_GNT1) && iOE1) || ((state_q == ST_GNT2) && iOE2);

endmodule

// File: tb/tb_zhyperram_bus_arbiter.sv
// Scoreboard bench for zhyperram_bus_arbiter: directed per-cycle vectors push expected
// outputs, a negedge monitor pops and compares {gnt1,gnt2,whichwr,tristate,busy,timeout}.
module tb_zhyperram_bus_arbiter;

  logic iClk = 1'b0;
  logic iRst_N, iReq1, iReq2, iDone1, iDone2, iOE1, iOE2;
  logic oGnt1, oGnt2, oWhichWr, oTriState, oBusy, oTimeout;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  zhyperram_bus_arbiter #(.TURN_CYCLES(2), .MAX_HOLD(8), .CNT_W(4)) dut (
    .iClk(iClk), .iRst_N(iRst_N),
    .iReq1(iReq1), .iReq2(iReq2), .iDone1(iDone1), .iDone2(iDone2),
    .iOE1(iOE1), .iOE2(iOE2),
    .oGnt1(oGnt1), .oGnt2(oGnt2), .oWhichWr(oWhichWr), .oTriState(oTriState),
    .oBusy(oBusy), .oTimeout(oTimeout)
  );

  always #5 iClk = ~iClk;

  // Expected output codes {g1,g2,ww,ts,busy,to}
  localparam logic [5:0] E_IDLE0 = 6'b000000;
  localparam logic [5:0] E_G1_T  = 6'b100110;
  localparam logic [5:0] E_G1_Z  = 6'b100010;
  localparam logic [5:0] E_G2_T  = 6'b011110;
  localparam logic [5:0] E_TRN0  = 6'b000010;
  localparam logic [5:0] E_TRN1  = 6'b001010;
  localparam logic [5:0] E_TMO1  = 6'b001011;

  // One cycle: drive inputs just after the edge and queue the outputs expected this cycle.
  task automatic cyc(input logic rst, input logic r1, input logic r2, input logic d1,
                     input logic d2, input logic o1, input logic o2,
                     input logic [5:0] e, input string nm);
    sb_item_t it;
    @(posedge iClk);
    #1;
    iRst_N = rst; iReq1 = r1; iReq2 = r2; iDone1 = d1; iDone2 = d2; iOE1 = o1; iOE2 = o2;
    it.exp  = e;
    it.name = nm;
    sb.push_back(it);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  initial begin
    sb_item_t it;
    logic [5:0] act;
    forever begin
      @(negedge iClk);
      if (sb.size() != 0) begin
        it  = sb.pop_front();
        act = {oGnt1, oGnt2, oWhichWr, oTriState, oBusy, oTimeout};
        n_checks++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s @%0t: got g1g2/ww/ts/busy/to=%b expected %b", it.name, $time, act, it.exp);
        end
      end
    end
  end

  initial begin
    iRst_N = 1'b0; iReq1 = 1'b0; iReq2 = 1'b0; iDone1 = 1'b0; iDone2 = 1'b0;
    iOE1 = 1'b0; iOE2 = 1'b0;

    // Reset, then single requester 1
    cyc(0, 0, 0, 0, 0, 0, 0, E_IDLE0, "reset_state");
    cyc(1, 1, 0, 0, 0, 1, 0, E_IDLE0, "idle_no_tristate");
    cyc(1, 1, 0, 0, 0, 1, 0, E_G1_T,  "gnt1_single_req");
    cyc(1, 1, 0, 0, 0, 0, 0, E_G1_Z,  "tristate_follows_oe1");
    // Non-owner OE and done are ignored
    cyc(1, 1, 0, 0, 1, 0, 1, E_G1_Z,  "oe2_ignored_in_gnt1");
    cyc(1, 1, 0, 0, 0, 1, 1, E_G1_T,  "done2_ignored_in_gnt1");
    // Release by dropping request, turnaround, back to idle
    cyc(1, 0, 0, 0, 0, 0, 0, E_G1_Z,  "gnt1_before_release");
    cyc(1, 0, 0, 0, 0, 1, 0, E_TRN0,  "turn_a_hiz");
    cyc(1, 0, 0, 0, 0, 1, 0, E_TRN0,  "turn_b_hiz");
    cyc(1, 0, 0, 0, 0, 0, 0, E_IDLE0, "idle_after_turn");

    // Tie after reset goes to requester 1, then done1 hands over after 2 turn cycles
    cyc(0, 0, 0, 0, 0, 0, 0, E_IDLE0, "reset_again");
    cyc(1, 1, 1, 0, 0, 1, 1, E_IDLE0, "idle_before_tie");
    cyc(1, 1, 1, 1, 0, 1, 1, E_G1_T,  "tie_gnt1_first");
    cyc(1, 1, 1, 0, 0, 1, 1, E_TRN0,  "turn1_after_done1");
    cyc(1, 1, 1, 0, 0, 1, 1, E_TRN0,  "turn2_after_done1");
    // Requester 2 holds with requester 1 pending: 8 granted cycles then timeout
    for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0, 0, 1, 1, E_G2_T, "gnt2_hold");
    cyc(1, 1, 1, 0, 0, 1, 1, E_TMO1,  "timeout_pulse_turn1");
    cyc(1, 1, 1, 0, 0, 1, 1, E_TRN1,  "turn2_after_timeout");
    cyc(1, 0, 0, 0, 0, 1, 0, E_G1_T,  "gnt1_after_timeout");
    cyc(1, 0, 0, 0, 0, 1, 0, E_TRN0,  "turn_a_after_gnt1");
    cyc(1, 0, 0, 0, 0, 1, 0, E_TRN0,  "turn_b_after_gnt1");
    cyc(1, 0, 1, 0, 0, 0, 1, E_IDLE0, "idle_before_long_hold");

    // Requester 2 alone for 2000 cycles: no timeout
    for (int i = 0; i < 2000; i++) cyc(1, 0, 1, 0, 0, 0, 1, E_G2_T, "gnt2_alone_no_timeout");

    // Reset mid-GNT2 drops grant and pad in the same edge; next tie goes to requester 1
    cyc(0, 1, 1, 0, 0, 1, 1, E_G2_T,  "gnt2_before_reset");
    cyc(1, 1, 1, 0, 0, 1, 1, E_IDLE0, "reset_mid_gnt2");
    cyc(1, 0, 0, 0, 0, 1, 1, E_G1_T,  "tie_after_reset_gnt1");
    cyc(1, 0, 0, 0, 0, 1, 1, E_TRN0,  "turn_a_final");
    cyc(1, 0, 0, 0, 0, 1, 1, E_TRN0,  "turn_b_final");
    cyc(1, 0, 0, 0, 0, 1, 1, E_IDLE0, "idle_final");

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge iClk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zhyperram_bus_arbiter.md
Name: zhyperram_bus_arbiter

Overview:
- Arbitrates the shared HyperRAM bidirectional pad group between two requesters (FPGA-1#, FPGA-2#).
- Drives the write-data select and tri-state enable of the pad mux.
- Guarantees exclusive ownership, a fixed bus-turnaround gap between owners, round-robin fairness and a hold-time limit when the other side is waiting.

Parameters:
TURN_CYCLES, 2, idle cycles (pad High-Z, no grant) between releases and the next grant; legal range 1..15.
MAX_HOLD, 1024, max consecutive granted cycles while the other requester waits; 0 disables the limit.
CNT_W, 11, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
iClk  input  1  system clock; all logic on rising edge.
iRst_N  input  1  synchronous reset, active-low.
iReq1  input  1  requester 1 wants the bus; level, held until done.
iReq2  input  1  requester 2 wants the bus.
iDone1  input  1  1-cycle release pulse from requester 1 (ignored unless granted).
iDone2  input  1  1-cycle release pulse from requester 2.
iOE1  input  1  requester 1 wants to drive the pad this cycle.
iOE2  input  1  requester 2 wants to drive the pad this cycle.
oGnt1  output  1  requester 1 owns the bus.
oGnt2  output  1  requester 2 owns the bus.
oWhichWr  output  1  pad-mux data select: 0 = requester 1, 1 = requester 2.
oTriState  output  1  pad drive enable: 1 = output, 0 = High-Z.
oBusy  output  1  state != IDLE.
oTimeout  output  1  1-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- States: IDLE, GNT1, GNT2, TURN. A registered state drives the grants.
- Reset (iRst_N=0 sampled on iClk edge):
  - state=IDLE, oGnt1=oGnt2=0, oWhichWr=0, oTriState=0, oBusy=0, oTimeout=0.
  - lastOwner=2 (so requester 1 wins the first tie).
  - Hold and turn counters cleared.
  - Reset mid-grant drops the grant and High-Zs the pad in the same edge.
- IDLE:
  - Only iReq1 -> GNT1 next edge; only iReq2 -> GNT2.
  - Both -> the requester that is not lastOwner.
  - Grant latency: request high at edge N -> oGntX=1 after edge N+1.
- GNTx:
  - oGntx=1; oWhichWr=x-1, registered on entry and held through TURN/IDLE until the next grant.
  - lastOwner=x.
  - Hold counter cleared on entry, increments each cycle, saturates at MAX_HOLD.
- oTriState is combinational from registered state: (state==GNT1 & iOE1) | (state==GNT2 & iOE2). It is never 1 in IDLE/TURN.
- Release: in GNTx, iDonex=1 or iReqx=0 -> TURN next edge. iDone from the non-owner is ignored.
- Timeout:
  - In GNTx with MAX_HOLD!=0, hold counter == MAX_HOLD-1 and the other iReq=1 -> TURN next edge, oTimeout=1 for that one cycle.
  - If the other side is not requesting, the grant continues indefinitely.
  - Release and timeout in the same cycle -> treated as release, oTimeout=0.
- TURN:
  - Grants 0, pad High-Z, turn counter counts TURN_CYCLES cycles.
  - On the last TURN cycle, arbitrate exactly as IDLE and go straight to GNTx, or to IDLE if no requests.
  - The requester just released may be re-granted if it alone requests.
- oGnt1 & oGnt2 is never 1; oTriState=1 only under a grant.
- Requests arriving during TURN are held by level, not lost.

Test Plan:
- Reset, iReq1=1 only -> oGnt1=1 two edges after reset release; oWhichWr=0; iOE1=1 -> oTriState=1 same cycle.
- iReq1=iReq2=1 from IDLE after reset -> GNT1 first. iDone1 -> exactly TURN_CYCLES=2 cycles with grants 0 and oTriState=0, then oGnt2=1, oWhichWr=1.
- Requester 2 holds with iReq1 pending, MAX_HOLD=8 -> oGnt2 high exactly 8 cycles, oTimeout pulses 1 cycle, then 2 TURN cycles, then oGnt1=1.
- Requester 2 holds alone for 2000 cycles with MAX_HOLD=8 -> no timeout, grant continuous.
- iOE2=1 while GNT1 and iDone2 pulse while GNT1 -> oTriState tracks iOE1 only; grant unaffected.
- Assert iRst_N=0 mid-GNT2 with iOE2=1 -> next edge oGnt2=0, oTriState=0, oWhichWr=0; the first tie after reset goes to requester 1.
